fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 73 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional FETCH_MISALIGN_CHECK_EN adds word-aligned redirect targets and a sticky FetchMisalign flag.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] IMemA,
    input  logic [31:0] IMemRD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        FetchMisalign
`endif
);

    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [31:0] redirect_pc;

    assign IMemA      = pc_f;
    assign pc_plus4_f = pc_f + 32'd4;

`ifdef FETCH_MISALIGN_CHECK_EN
    // Redirects are forced onto a word boundary; the flag records that it happened.
    assign redirect_pc = {PCTargetE[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            FetchMisalign <= 1'b0;
        end else if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
            FetchMisalign <= 1'b1;
        end
    end
`else
    assign redirect_pc = PCTargetE;
`endif

    // Redirect wins over a fetch stall so a taken branch is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f <= RESET_VECTOR;
        end else if (PCSrcE) begin
            pc_f <= redirect_pc;
        end else if (!StallF) begin
            pc_f <= pc_plus4_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= IMemRD;
            PCD      <= pc_f;
            PCPlus4D <= pc_plus4_f;
            ValidD   <= 1'b1;
        end
    end

endmodule
